// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss / write-through controller with write-allocate refill.
// Optional load-miss counter port miss_cnt_o when MISS_CNT_EN is defined.
module dcache_refill_ctrl #(
  parameter int INDEX_W        = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_i,
  input  logic                 wr_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [31:0]          mem_rdata_i,
  output logic                 fill_we_o,
  output logic [INDEX_W-1:0]   fill_index_o,
  output logic [29-INDEX_W:0]  fill_tag_o,
  output logic [31:0]          fill_data_o,
  output logic                 err_o
`ifdef MISS_CNT_EN
 ,output logic [31:0]          miss_cnt_o
`endif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FILL,
    DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  assign stall_o = ((state_q == IDLE) && (miss_i || wr_i))
                 || (state_q == BUSY)
                 || (state_q == FILL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      fill_we_o    <= 1'b0;
      fill_index_o <= '0;
      fill_tag_o   <= '0;
      fill_data_o  <= '0;
      err_o        <= 1'b0;
`ifdef MISS_CNT_EN
      miss_cnt_o   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_i || miss_i) begin
            state_q     <= BUSY;
            cnt_q       <= '0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= wr_i;
            mem_addr_o  <= addr_i & 32'hFFFF_FFFC;
            mem_wdata_o <= wdata_i;
          end
        end
        BUSY: begin
          // An ack on the final counted cycle still completes normally
          if (mem_ack_i) begin
            state_q      <= FILL;
            fill_we_o    <= 1'b1;
            fill_index_o <= mem_addr_o[INDEX_W+1:2];
            fill_tag_o   <= mem_addr_o[31:INDEX_W+2];
            fill_data_o  <= mem_we_o ? mem_wdata_o : mem_rdata_i;
`ifdef MISS_CNT_EN
            if (!mem_we_o) miss_cnt_o <= miss_cnt_o + 32'd1;
`endif
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            err_o   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (mem_ack_i || (cnt_q == CNT_LAST)) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
          end
        end
        FILL: begin
          state_q      <= DONE;
          fill_we_o    <= 1'b0;
          fill_index_o <= '0;
          fill_tag_o   <= '0;
          fill_data_o  <= '0;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: vector table, corner sequences
// and randomized transactions checked against a transaction-level model.
module tb_dcache_refill_ctrl;

  localparam int IW    = 3;
  localparam int TW    = 32 - IW - 2;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_i, wr_i;
  logic [31:0]   addr_i, wdata_i;
  logic          stall_o, mem_req_o, mem_we_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i;
  logic          fill_we_o;
  logic [IW-1:0] fill_index_o;
  logic [TW-1:0] fill_tag_o;
  logic [31:0]   fill_data_o;
  logic          err_o;
`ifdef MISS_CNT_EN
  logic [31:0]   miss_cnt_o;
`endif

  dcache_refill_ctrl #(.INDEX_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .miss_i(miss_i), .wr_i(wr_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .fill_we_o(fill_we_o), .fill_index_o(fill_index_o),
    .fill_tag_o(fill_tag_o), .fill_data_o(fill_data_o),
    .err_o(err_o)
`ifdef MISS_CNT_EN
   ,.miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          miss;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    int            k;
    logic          e_we;
    logic [31:0]   e_addr;
    int            e_stall;
    int            e_req;
    logic          e_fill;
    logic [IW-1:0] e_idx;
    logic [TW-1:0] e_tag;
    logic [31:0]   e_data;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_mc = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: k = ack delay in BUSY cycles, k<0 = never
  function automatic vec_t predict(input logic miss, input logic wr,
                                   input logic [31:0] addr,
                                   input logic [31:0] wdata,
                                   input logic [31:0] rdata, input int k);
    vec_t v;
    bit   acked;
    v.miss  = miss;
    v.wr    = wr;
    v.addr  = addr;
    v.wdata = wdata;
    v.rdata = rdata;
    v.k     = k;
    acked   = (k >= 0) && (k < TO);
    v.e_we    = wr;
    v.e_addr  = addr - (addr % 4);
    v.e_stall = acked ? 3 + k : 1 + TO;
    v.e_req   = acked ? k + 1 : TO;
    v.e_fill  = acked;
    v.e_idx   = IW'((v.e_addr / 4) % (1 << IW));
    v.e_tag   = TW'(v.e_addr >> (IW + 2));
    v.e_data  = wr ? wdata : rdata;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    int            stall_n = 0;
    int            req_n = 0;
    int            fill_n = 0;
    int            bus_bad = 0;
    int            idle_bad = 0;
    logic [IW-1:0] f_idx = '0;
    logic [TW-1:0] f_tag = '0;
    logic [31:0]   f_data = '0;
    miss_i    = v.miss;
    wr_i      = v.wr;
    addr_i    = v.addr;
    wdata_i   = v.wdata;
    mem_ack_i = 1'b0;
    #1;
    if (stall_o) stall_n++;
    step();
    miss_i  = 1'b0;
    wr_i    = 1'b0;
    addr_i  = $urandom;
    wdata_i = $urandom;
    for (int c = 1; c < 60; c++) begin
      mem_ack_i   = (c == 1 + v.k);
      mem_rdata_i = (c == 1 + v.k) ? v.rdata : $urandom;
      #1;
      if (!stall_o) begin
        if (mem_req_o || fill_we_o) idle_bad++;
        break;
      end
      stall_n++;
      if (mem_req_o) begin
        req_n++;
        if (mem_we_o !== v.e_we || mem_addr_o !== v.e_addr ||
            mem_wdata_o !== v.wdata)
          bus_bad++;
      end else if (mem_we_o || mem_addr_o != 0 || mem_wdata_o != 0) begin
        idle_bad++;
      end
      if (fill_we_o) begin
        fill_n++;
        f_idx  = fill_index_o;
        f_tag  = fill_tag_o;
        f_data = fill_data_o;
      end else if (fill_index_o != 0 || fill_tag_o != 0 || fill_data_o != 0) begin
        idle_bad++;
      end
      step();
    end
    mem_ack_i = 1'b0;
    step();
    if (!v.e_fill) exp_err = 1'b1;
    if (v.e_fill && !v.wr) exp_mc = exp_mc + 32'd1;
    chk({nm, ".stall_cycles"}, stall_n, v.e_stall);
    chk({nm, ".req_cycles"}, req_n, v.e_req);
    chk({nm, ".fill_pulses"}, fill_n, v.e_fill ? 1 : 0);
    if (v.e_fill) begin
      chk({nm, ".fill_index"}, f_idx, v.e_idx);
      chk({nm, ".fill_tag"}, f_tag, v.e_tag);
      chk({nm, ".fill_data"}, f_data, v.e_data);
    end
    chk({nm, ".bus_value"}, bus_bad, 0);
    chk({nm, ".inactive_zero"}, idle_bad, 0);
    chk({nm, ".err"}, err_o, exp_err);
`ifdef MISS_CNT_EN
    chk({nm, ".miss_cnt"}, miss_cnt_o, exp_mc);
`endif
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   fc;
    int   bad;
    rst = 1'b0; miss_i = 0; wr_i = 0; addr_i = 0; wdata_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0, 32'hDEAD_BEEF, 2,
                1'b0, 32'h0000_1234, 5, 3, 1'b1, 3'd5, 27'h91, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'h1111_2222, 0,
                1'b1, 32'h0000_0010, 3, 1, 1'b1, 3'd4, 27'h0, 32'hA5A5_A5A5};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0F07, 32'h1234_5678, 32'hFFFF_0000, 1,
                1'b1, 32'h0000_0F04, 4, 2, 1'b1, 3'd1, 27'h78, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0BAD_F00D, 15,
                1'b0, 32'hFFFF_FFFC, 18, 16, 1'b1, 3'd7, 27'h7FF_FFFF,
                32'h0BAD_F00D};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, -1,
                1'b0, 32'h0000_0040, 17, 16, 1'b0, 3'd0, 27'h0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_01F0, 32'h0, 32'h0102_0304, 0,
                1'b0, 32'h0000_01F0, 3, 1, 1'b1, 3'd4, 27'hF, 32'h0102_0304};

    step(); step();
    rst = 1'b1;
    #1;
    chk("reset.stall", stall_o, 0);
    chk("reset.mem_req", mem_req_o, 0);
    chk("reset.fill_we", fill_we_o, 0);
    chk("reset.err", err_o, 0);
    chk("reset.mem_addr", mem_addr_o, 0);
    step();

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // DONE must ignore a still-asserted miss, then IDLE picks it up again
    miss_i = 1; addr_i = 32'h200; mem_rdata_i = 32'hCAFE_0001;
    step();
    mem_ack_i = 1;
    step();
    mem_ack_i = 0;
    step();
    chk("done.stall_low", stall_o, 0);
    step();
    chk("done.idle_restart", stall_o, 1);
    step();
    miss_i = 0;
    chk("done.second_req", mem_req_o, 1);
    chk("done.second_addr", mem_addr_o, 32'h200);
    mem_ack_i = 1; mem_rdata_i = 32'hCAFE_0002;
    step();
    mem_ack_i = 0;
    chk("done.second_fill", fill_we_o, 1);
    chk("done.second_data", fill_data_o, 32'hCAFE_0002);
    exp_mc = exp_mc + 32'd2;
    step(); step();

    // Reset while BUSY: request dropped, later ack ignored, err cleared
    miss_i = 1; addr_i = 32'h80;
    step();
    miss_i = 0;
    step(); step();
    chk("rstbusy.pre_req", mem_req_o, 1);
    rst = 0;
    step();
    rst = 1;
    chk("rstbusy.mem_req", mem_req_o, 0);
    chk("rstbusy.mem_addr", mem_addr_o, 0);
    chk("rstbusy.stall", stall_o, 0);
    chk("rstbusy.err", err_o, 0);
    exp_err = 0;
    exp_mc  = '0;
    mem_ack_i = 1; mem_rdata_i = 32'h5555_AAAA;
    fc = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      mem_ack_i = 0;
      if (fill_we_o || stall_o || mem_req_o) fc++;
    end
    chk("rstbusy.late_ack_ignored", fc, 0);

    // Randomized transactions with idle gaps carrying stray acks
    for (int t = 0; t < 50; t++) begin
      int    ty;
      int    kk;
      int    r;
      logic  m;
      logic  w;
      ty = $urandom_range(0, 2);
      m  = (ty != 1);
      w  = (ty != 0);
      r  = $urandom_range(0, 9);
      kk = (r == 0) ? -1 : (r == 1) ? TO - 1 : $urandom_range(0, 4);
      v  = predict(m, w, $urandom, $urandom, $urandom, kk);
      run_txn(v, $sformatf("rnd%0d", t));
      bad = 0;
      for (int g = 0; g < $urandom_range(1, 3); g++) begin
        mem_ack_i = $urandom_range(0, 1);
        mem_rdata_i = $urandom;
        #1;
        if (stall_o || mem_req_o || fill_we_o) bad++;
        step();
      end
      mem_ack_i = 0;
      chk($sformatf("rnd%0d.gap_quiet", t), bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
